inst_mem_loader: RTL and testbench

Boot-time writer for the CPU instruction memory. It takes a byte stream from the UART receiver, checks the framing and a checksum, and assembles big-endian 32-bit instruction words. Each word is written into the instruction RAM through a single write port. The CPU is held in reset until a valid image has been loaded, which replaces the fixed ROM contents with a downloadable program.

---
 rtl/inst_mem_loader_if.sv | 19 +
 rtl/inst_mem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the loader and the
// instruction RAM write port.
interface inst_mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: A5 / len / payload / xor-checksum frames into instruction RAM.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module inst_mem_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  inst_mem_loader_if.slave      bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int          CW    = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    SYNC, LEN, DATA, CHK, DONE, ERR
  } state_t;

  state_t          state, state_d;
  logic [1:0]      bidx, bidx_d;
  logic [CW-1:0]   widx, widx_d;
  logic [CW-1:0]   nwords, nwords_d;
  logic [CW-1:0]   wcnt_d;
  logic [23:0]     shreg, shreg_d;
  logic [7:0]      csum, csum_d;
  logic            we_d;
  logic [31:0]     addr_d, wdata_d;
  logic            done_d, error_d, hold_d;
  logic [8:0]      len_n;
  logic            sync_hit;
  logic            in_frame;
  logic            tmo_hit;

  assign len_n    = (bus.rx_data == 8'h00) ? 9'd256
                                           : {1'b0, bus.rx_data};
  assign sync_hit = bus.rx_valid && (bus.rx_data == 8'hA5);
  assign in_frame = (state == LEN) || (state == DATA)
                 || (state == CHK);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo, tmo_d;

  // Idle-cycle counter, cleared by any received byte or outside a frame.
  always_comb begin
    tmo_d = '0;
    if (in_frame && !bus.rx_valid)
      tmo_d = tmo + 32'd1;
  end

  assign tmo_hit = in_frame && !bus.rx_valid
                && (tmo == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) tmo <= '0;
    else       tmo <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame parser: next state and next values of every output register.
  always_comb begin
    state_d  = state;
    bidx_d   = bidx;
    widx_d   = widx;
    nwords_d = nwords;
    wcnt_d   = word_count;
    shreg_d  = shreg;
    csum_d   = csum;
    we_d     = 1'b0;
    addr_d   = bus.mem_addr;
    wdata_d  = bus.mem_wdata;
    done_d   = done;
    error_d  = error;
    hold_d   = cpu_hold;

    unique case (state)
      SYNC: begin
        if (sync_hit) begin
          state_d = LEN;
          error_d = 1'b0;
          wcnt_d  = '0;
        end
      end
      LEN: begin
        if (tmo_hit) begin
          state_d = ERR;
          error_d = 1'b1;
          hold_d  = 1'b1;
        end else if (bus.rx_valid) begin
          if (32'(len_n) > DEPTH) begin
            state_d = ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end else begin
            state_d  = DATA;
            nwords_d = CW'(len_n);
            bidx_d   = '0;
            widx_d   = '0;
            csum_d   = '0;
          end
        end
      end
      DATA: begin
        if (tmo_hit) begin
          state_d = ERR;
          error_d = 1'b1;
          hold_d  = 1'b1;
        end else if (bus.rx_valid) begin
          csum_d  = csum ^ bus.rx_data;
          shreg_d = {shreg[15:0], bus.rx_data};
          bidx_d  = bidx + 2'd1;
          if (bidx == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(widx) << 2);
            wdata_d = {shreg, bus.rx_data};
            wcnt_d  = word_count + CW'(1);
            widx_d  = widx + CW'(1);
            if (widx_d == nwords)
              state_d = CHK;
          end
        end
      end
      CHK: begin
        if (tmo_hit) begin
          state_d = ERR;
          error_d = 1'b1;
          hold_d  = 1'b1;
        end else if (bus.rx_valid) begin
          if (bus.rx_data == csum) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = SYNC;
          done_d  = 1'b0;
          hold_d  = 1'b1;
        end
      end
      ERR: begin
        if (start) begin
          state_d = SYNC;
        end else if (sync_hit) begin
          state_d = LEN;
          error_d = 1'b0;
          wcnt_d  = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SYNC;
      bidx          <= '0;
      widx          <= '0;
      nwords        <= '0;
      word_count    <= '0;
      shreg         <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_hold      <= 1'b1;
    end else begin
      state         <= state_d;
      bidx          <= bidx_d;
      widx          <= widx_d;
      nwords        <= nwords_d;
      word_count    <= wcnt_d;
      shreg         <= shreg_d;
      csum          <= csum_d;
      bus.mem_we    <= we_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      done          <= done_d;
      error         <= error_d;
      cpu_hold      <= hold_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized frame-level bench for inst_mem_loader.
// Expects error after a 16-cycle stall only when LOADER_TIMEOUT_EN is defined.
module tb_inst_mem_loader;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  inst_mem_loader_if bus ();

  always #5 clk = ~clk;

  inst_mem_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          n;
  } wr_t;

  wr_t exp_wr[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the next write predicted by the model.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("spurious_we", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e.a));
        check("wr_data", 64'(bus.mem_wdata), 64'(e.d));
        check("wr_count", 64'(word_count), 64'(e.n));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Frame model: payload words big-endian, checksum = xor of payload bytes.
  task automatic send_frame(input logic [31:0] w[$],
                            input bit bad,
                            input bit gaps);
    logic [7:0]  cs;
    logic [31:0] word;
    logic [7:0]  b;
    wr_t         e;
    cs = 8'h00;
    for (int i = 0; i < w.size(); i++) begin
      e.a = BASE + 32'(4 * i);
      e.d = w[i];
      e.n = i + 1;
      exp_wr.push_back(e);
    end
    send_byte(8'hA5);
    send_byte(8'(w.size()));
    for (int i = 0; i < w.size(); i++) begin
      word = w[i];
      for (int k = 3; k >= 0; k--) begin
        b  = word[8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
        if (gaps) idle($urandom_range(0, 2));
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic check_result(input string tag,
                              input bit ok,
                              input int n);
    check({tag, "_done"}, 64'(done), ok ? 64'd1 : 64'd0);
    check({tag, "_err"}, 64'(error), ok ? 64'd0 : 64'd1);
    check({tag, "_hold"}, 64'(cpu_hold), ok ? 64'd0 : 64'd1);
    check({tag, "_wcnt"}, 64'(word_count), 64'(n));
  endtask

  initial begin
    logic [31:0] w[$];
    int          n;
    bit          bad;
    bit          in_done;

    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(error), 64'd0);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'(BASE));
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_wcnt", 64'(word_count), 64'd0);
    reset = 1'b0;

    send_byte(8'h00);
    send_byte(8'h3C);
    check("junk_done", 64'(done), 64'd0);
    check("junk_hold", 64'(cpu_hold), 64'd1);

    w = '{32'h3C14_4000, 32'h2294_000C};
    send_frame(w, 1'b0, 1'b0);
    check_result("fixed", 1'b1, 2);

    send_byte(8'(($urandom)));
    check("done_ign_done", 64'(done), 64'd1);
    check("done_ign_wcnt", 64'(word_count), 64'd2);

    @(negedge clk);
    start        = 1'b1;
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("rearm_done", 64'(done), 64'd0);
    check("rearm_hold", 64'(cpu_hold), 64'd1);

    w = '{32'hDEAD_BEEF, 32'h0000_0013, 32'h1234_5678};
    send_frame(w, 1'b0, 1'b1);
    check_result("after_rearm", 1'b1, 3);
    pulse_start();

    w = '{32'h3C14_4000, 32'h2294_000C};
    send_frame(w, 1'b1, 1'b0);
    check_result("badcs", 1'b0, 2);
    send_frame(w, 1'b0, 1'b0);
    check_result("fixcs", 1'b1, 2);
    in_done = 1'b1;

    for (int it = 0; it < 8; it++) begin
      if (in_done) pulse_start();
      n   = $urandom_range(1, 8);
      bad = ($urandom_range(0, 2) == 0);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      send_frame(w, bad, 1'b1);
      check_result("rand", !bad, n);
      in_done = !bad;
    end

    if (in_done) pulse_start();
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    send_frame(w, 1'b0, 1'b0);
    check_result("full256", 1'b1, 256);

    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    check("mid_rst_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(error), 64'd0);
    check("mid_rst_we", 64'(bus.mem_we), 64'd0);
    check("mid_rst_addr", 64'(bus.mem_addr), 64'(BASE));
    check("mid_rst_wcnt", 64'(word_count), 64'd0);
    w = '{32'hCAFE_F00D};
    send_frame(w, 1'b0, 1'b1);
    check_result("post_rst", 1'b1, 1);

    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    idle(16);
`ifdef LOADER_TIMEOUT_EN
    check("stall_err", 64'(error), 64'd1);
`else
    check("stall_err", 64'(error), 64'd0);
`endif
    check("stall_hold", 64'(cpu_hold), 64'd1);
    check("stall_done", 64'(done), 64'd0);
    do_reset();

    idle(2);
    check("pending_wr", 64'(exp_wr.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
